// File: rtl/alu_pkg.sv
// Shared funct codes, FSM state type and decode helper for the EX-stage ALU.
package alu_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] F_SRL   = 6'd2;
  localparam logic [FUNCT_W-1:0] F_MFHI  = 6'd16;
  localparam logic [FUNCT_W-1:0] F_MFLO  = 6'd18;
  localparam logic [FUNCT_W-1:0] F_MULTU = 6'd25;
  localparam logic [FUNCT_W-1:0] F_DIVU  = 6'd27;
  localparam logic [FUNCT_W-1:0] F_ADD   = 6'd32;
  localparam logic [FUNCT_W-1:0] F_SUB   = 6'd34;
  localparam logic [FUNCT_W-1:0] F_AND   = 6'd36;
  localparam logic [FUNCT_W-1:0] F_OR    = 6'd37;
  localparam logic [FUNCT_W-1:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  function automatic logic is_multicycle(input logic [FUNCT_W-1:0] code);
    return (code == F_MULTU) || (code == F_DIVU);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle datapath and funct-code legality decode.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [FUNCT_W-1:0] code,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               illegal
);

  localparam int SH_W = $clog2(WIDTH);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  // HI/LO moves and MUL/DIV are legal here but produced by the top level.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (code)
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_SLT:   result = {{(WIDTH-1){1'b0}}, lt};
      F_SRL:   result = a >> b[SH_W-1:0];
      F_MFHI, F_MFLO, F_MULTU, F_DIVU: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_alu_muldiv.sv
// Registered EX-stage ALU with iterative MULTU/DIVU, HI/LO and valid/ready handshake.
// state | meaning
// IDLE  | ready; single-cycle ops complete on the accept edge
// MUL   | shift-add multiply, one bit per edge
// DIV   | restoring divide, one bit per edge
module pipe_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIGNAL_W = 6,
  parameter int CNT_W    = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    dataA,
  input  logic [WIDTH-1:0]    dataB,
  input  logic [SIGNAL_W-1:0] Signal,
  output logic [WIDTH-1:0]    dataOut,
  output logic                out_valid,
  output logic                illegal,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     counter;
  logic [WIDTH-1:0]     acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [FUNCT_W-1:0]   code;
  logic [WIDTH-1:0]     core_result;
  logic                 core_illegal;
  logic                 accept, last;

  assign code   = FUNCT_W'(Signal);
  assign accept = in_valid & in_ready & ~flush;
  assign last   = (counter == CNT_W'(WIDTH - 1));

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .code    (code),
    .a       (dataA),
    .b       (dataB),
    .result  (core_result),
    .illegal (core_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_multicycle(code))
                 state_nx = (code == F_MULTU) ? MUL : DIV;
      MUL, DIV: if (flush || last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // acc_hi holds partial product / remainder; acc_lo holds multiplier / quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift - {1'b0, opnd};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (state == DIV) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      hi        <= '0;
      lo        <= '0;
      dataOut   <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (accept) begin
        counter <= '0;
        acc_hi  <= '0;
        if (code == F_MULTU) begin
          acc_lo <= dataB;
          opnd   <= dataA;
        end else if (code == F_DIVU) begin
          acc_lo <= dataA;
          opnd   <= dataB;
        end else begin
          out_valid <= 1'b1;
          illegal   <= core_illegal;
          if (code == F_MFHI)      dataOut <= hi;
          else if (code == F_MFLO) dataOut <= lo;
          else                     dataOut <= core_result;
        end
      end else if (state != IDLE && !flush) begin
        acc_hi  <= step_hi;
        acc_lo  <= step_lo;
        counter <= counter + 1'b1;
        if (last) begin
          hi        <= step_hi;
          lo        <= step_lo;
          dataOut   <= step_lo;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_alu_muldiv.sv
// Directed-vector bench for pipe_alu_muldiv at WIDTH=32.
module tb_pipe_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic [5:0]   Signal = '0;
  logic [W-1:0] dataOut, hi, lo;
  logic         out_valid, illegal, busy;

  int checks = 0;
  int errors = 0;

  pipe_alu_muldiv dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .Signal(Signal), .dataOut(dataOut),
    .out_valid(out_valid), .illegal(illegal), .busy(busy), .hi(hi), .lo(lo)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    Signal   = code;
    dataA    = a;
    dataB    = b;
    in_valid = 1'b1;
  endtask

  // Single-cycle op: drive at negedge, accepted at posedge, checked at next negedge.
  task automatic op1(input string tag, input logic [5:0] code, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp);
    drive(code, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_out"}, dataOut, exp);
  endtask

  // Multi-cycle op: returns number of negedges spent with in_ready low.
  task automatic opm(input logic [5:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                     output int cyc);
    drive(code, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  int cyc;
  int pulses;
  logic [W-1:0] keep_out;

  initial begin
    @(negedge clk);
    #1;
    chk("rst_out", dataOut, 0);
    chk("rst_hi", hi, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back ADD then SUB with no bubble.
    drive(6'd32, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_out", dataOut, 32'h8000_0000);
    drive(6'd34, 32'd5, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sub_valid", out_valid, 1);
    chk("sub_out", dataOut, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("sub_pulse", out_valid, 0);

    op1("slt1", 6'd42, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
    op1("slt2", 6'd42, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    op1("srl", 6'd2, 32'h8000_0000, 32'd31, 32'h1);
    op1("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    op1("or", 6'd37, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);

    opm(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("mul_cyc", cyc, 32);
    chk("mul_valid", out_valid, 1);
    chk("mul_lo", lo, 32'h1);
    chk("mul_hi", hi, 32'hFFFF_FFFE);
    chk("mul_out", dataOut, 32'h1);
    op1("mfhi", 6'd16, 32'h0, 32'h0, 32'hFFFF_FFFE);
    op1("mflo", 6'd18, 32'h0, 32'h0, 32'h1);

    opm(6'd27, 32'd100, 32'd7, cyc);
    chk("div_cyc", cyc, 32);
    chk("div_valid", out_valid, 1);
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    opm(6'd27, 32'd9, 32'd0, cyc);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd9);

    // Reset in the middle of a multiply.
    drive(6'd25, 32'd3, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_out", dataOut, 0);
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("mrst_nopulse", pulses, 0);
    chk("mrst_ready2", in_ready, 1);

    // Flush during a divide leaves HI/LO and dataOut alone.
    opm(6'd27, 32'd100, 32'd7, cyc);
    keep_out = dataOut;
    drive(6'd27, 32'd50, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("flush_nopulse", pulses, 0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    chk("flush_out", dataOut, keep_out);

    // Illegal funct code.
    drive(6'd0, 32'h1234, 32'h5678);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_out", dataOut, 0);
    @(negedge clk);
    chk("ill_pulse", illegal, 0);

    // Flush coincident with in_valid: nothing accepted.
    drive(6'd25, 32'd2, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fin_valid", out_valid, 0);
    chk("fin_ready", in_ready, 1);
    chk("fin_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_alu_muldiv.md
Name: pipe_alu_muldiv

Overview:
- Parametrised, registered integer ALU for the pipelined CPU's EX stage, driven by the MIPS funct code.
- Keeps the single-cycle AND/OR/ADD/SUB/SLT set and adds SRL, iterative MULTU/DIVU with HI/LO registers, and MFHI/MFLO.
- Uses a valid/ready handshake so the hazard unit can stall the pipeline while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- SIGNAL_W, 6, width of the funct-code input.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the in-flight op.
- in_valid  input  1  operands and Signal are valid.
- in_ready  output  1  block can accept an op this cycle.
- dataA  input  WIDTH  operand A (rs).
- dataB  input  WIDTH  operand B (rt); SRL shift amount taken from dataB[CNT_W-2:0].
- Signal  input  SIGNAL_W  funct code.
- dataOut  output  WIDTH  registered result.
- out_valid  output  1  one-cycle pulse when dataOut is new.
- illegal  output  1  qualifies out_valid: code was unsupported.
- busy  output  1  MUL or DIV in progress.
- hi, lo  output  WIDTH  architectural HI/LO registers.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dataOut, hi, lo, counter = 0; out_valid, illegal, busy = 0; in_ready = 1 while IDLE. Reset mid-MUL/DIV aborts the op, and no out_valid is produced.
- Codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18.
- Accept = in_valid & in_ready & ~flush. in_ready = (state==IDLE).
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO):
  - dataOut is written at the accept edge; out_valid=1 for exactly the following cycle; state stays IDLE, so back-to-back accepts are allowed.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is a true signed compare (overflow-corrected): dataOut = {0...,A<B}.
  - SRL is a logical shift.
  - MFHI/MFLO return the hi/lo value held at the accept edge.
- Illegal code: dataOut=0, illegal=1, out_valid=1 one cycle after accept.
- MULTU, unsigned shift-add:
  - Accept edge loads operands, counter=0, state=MUL, busy=1.
  - Each edge in MUL performs one iteration.
  - At the WIDTH-th MUL edge: {hi,lo} <= A*B (2*WIDTH bits), dataOut <= low half, state=IDLE, out_valid=1.
  - Result is therefore visible WIDTH cycles after the accept edge; in_ready returns to 1 in that same out_valid cycle.
- DIVU, restoring, same timing as MULTU (state DIV): lo <= quotient, hi <= remainder, dataOut <= quotient.
- DIVU by zero is not special-cased; the algorithm yields lo=all ones, hi=dataA.
- flush:
  - While MUL/DIV: return to IDLE next edge; hi/lo and dataOut unchanged; no out_valid.
  - Coincident with in_valid: nothing is accepted.
  - Coincident with the completing edge: flush wins and the result is discarded.
- out_valid and illegal are never asserted for more than one cycle per accepted op.
- in_valid while busy is ignored; the upstream stage holds its inputs.

Decomposition:
- Package alu_pkg: funct-code localparams, state enum {IDLE, MUL, DIV}, and an is_multicycle(code) function.
- Sub-module alu_comb_core: purely combinational single-cycle datapath (AND/OR/ADD/SUB/SLT/SRL, illegal decode), parametrised by WIDTH.
- Top level: MUL/DIV FSM, counter, shift registers, HI/LO and output registers.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x1 -> dataOut 0x80000000, out_valid pulse 1 cycle after accept. SUB 5-7 on the next cycle -> 0xFFFFFFFE, back-to-back with no bubble.
- SLT A=0x80000000,B=0x7FFFFFFF -> 1. SLT A=0x7FFFFFFF,B=0xFFFFFFFF -> 0. SRL 0x80000000 by 31 -> 0x00000001.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> in_ready low 32 cycles; out_valid on cycle 32 with lo=0x00000001, hi=0xFFFFFFFE. A following MFHI -> 0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2 at cycle 32. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
- Drive reset=0 at MULTU cycle 10 -> all outputs 0 immediately, in_ready=1 after release. flush at DIVU cycle 5 -> no out_valid; hi/lo keep their prior values.
- Signal=0 -> out_valid=1, illegal=1, dataOut=0. flush coincident with in_valid -> no out_valid.
